// File: rtl/cpu_trace_buffer.sv
// Trace capture stage: samples {alu, instr, pc} into a small FIFO under a
// selectable trigger and drains it one byte per transfer to a debugger.
module cpu_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_en,
  input  logic [1:0]    trig_mode,
  input  logic [15:0]   trig_pc,
  input  logic [15:0]   pc_in,
  input  logic [15:0]   instr_in,
  input  logic [7:0]    alu_in,
  input  logic          clear,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic          rd_last,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          trig_done,
  output logic [2:0]    dbg_state
);
  // Handshake: a byte moves when rd_valid && rd_ready on a rising edge; once
  // raised, rd_valid and rd_data hold until that transfer (or reset/clear).

  localparam int AW = LW - 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    mode_q;
  logic [15:0]   last_pc;
  logic          last_pc_valid;
  logic          push_req, latch_mode, track_pc;

  logic [39:0]   mem [DEPTH];
  logic [39:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [2:0]    byte_idx;
  logic          full, xfer, pop, push, drop;

  assign full  = (count == FULL_LVL);
  assign xfer  = rd_valid && rd_ready;
  assign pop   = xfer && (byte_idx == 3'd4);
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  assign rd_valid  = (count != '0);
  assign rd_last   = rd_valid && (byte_idx == 3'd4);
  assign level     = count;
  assign trig_done = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    push_req   = 1'b0;
    latch_mode = 1'b0;
    track_pc   = 1'b0;
    if (state != S_IDLE && !capture_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (capture_en) begin
            latch_mode = 1'b1;
            state_nxt  = (trig_mode == 2'b11) ? S_ARMED : S_RUN;
          end
        end
        S_RUN: begin
          track_pc = 1'b1;
          case (mode_q)
            2'b00:   push_req = 1'b1;
            2'b01:   push_req = !last_pc_valid || (pc_in != last_pc);
            2'b10:   push_req = (pc_in == trig_pc);
            default: push_req = 1'b0;
          endcase
        end
        S_ARMED: begin
          if (pc_in == trig_pc) begin
            push_req  = 1'b1;
            state_nxt = S_CAPTURE;
          end
        end
        // The window closes on the first sample that no longer fits.
        S_CAPTURE: begin
          push_req = 1'b1;
          if (full && !pop) state_nxt = S_DONE;
        end
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      mode_q        <= 2'b00;
      last_pc       <= 16'h0000;
      last_pc_valid <= 1'b0;
    end else if (clear) begin
      state         <= S_IDLE;
      last_pc_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_mode) mode_q <= trig_mode;
      if (track_pc) begin
        last_pc       <= pc_in;
        last_pc_valid <= 1'b1;
      end else if (state_nxt == S_IDLE) begin
        last_pc_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      byte_idx <= 3'd0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      byte_idx <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (xfer) byte_idx <= pop ? 3'd0 : byte_idx + 3'd1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + LW'(push) - LW'(pop);
      if (drop && state != S_CAPTURE) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= {alu_in, instr_in, pc_in};
  end

  always_comb begin
    head    = mem[rd_ptr];
    rd_data = 8'h00;
    if (rd_valid) begin
      case (byte_idx)
        3'd0:    rd_data = head[7:0];
        3'd1:    rd_data = head[15:8];
        3'd2:    rd_data = head[23:16];
        3'd3:    rd_data = head[31:24];
        3'd4:    rd_data = head[39:32];
        default: rd_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed trace scenarios plus random traffic,
// all outputs compared every cycle against a queue-based trace model.
module tb_cpu_trace_buffer;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  localparam int PH_IDLE    = 0;
  localparam int PH_RUN     = 1;
  localparam int PH_ARMED   = 2;
  localparam int PH_CAPTURE = 3;
  localparam int PH_DONE    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          capture_en;
  logic [1:0]    trig_mode;
  logic [15:0]   trig_pc, pc_in, instr_in;
  logic [7:0]    alu_in;
  logic          clear, rd_ready;
  logic          rd_valid, rd_last, overflow, trig_done;
  logic [7:0]    rd_data;
  logic [LW-1:0] level;
  logic [2:0]    dbg_state;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Reference model: the trace as a queue of whole entries.
  logic [39:0] exp_q[$];
  logic [8:0]  got_q[$];
  int          m_idx, m_phase;
  logic [1:0]  m_mode;
  logic        m_ovf, m_last_valid;
  logic [15:0] m_last_pc;

  cpu_trace_buffer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .trig_mode(trig_mode),
    .trig_pc(trig_pc), .pc_in(pc_in), .instr_in(instr_in), .alu_in(alu_in),
    .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .level(level), .overflow(overflow),
    .trig_done(trig_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] m_byte();
    logic [39:0] e;
    if (exp_q.size() == 0) return 8'h00;
    e = exp_q[0];
    return e[8*m_idx +: 8];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_idx = 0; m_ovf = 1'b0; m_phase = PH_IDLE; m_last_valid = 1'b0;
  endtask

  task automatic model_update();
    bit pop, try_push, accept;
    int nxt;
    if (clear) begin
      model_reset();
      return;
    end
    pop = (exp_q.size() != 0) && rd_ready && (m_idx == 4);
    try_push = 1'b0;
    nxt = m_phase;
    if (m_phase != PH_IDLE && !capture_en) begin
      nxt = PH_IDLE;
      m_last_valid = 1'b0;
    end else if (m_phase == PH_IDLE) begin
      if (capture_en) begin
        m_mode = trig_mode;
        nxt = (trig_mode == 2'b11) ? PH_ARMED : PH_RUN;
      end
    end else if (m_phase == PH_RUN) begin
      if (m_mode == 2'b00) try_push = 1'b1;
      else if (m_mode == 2'b01) try_push = !m_last_valid || (pc_in != m_last_pc);
      else if (m_mode == 2'b10) try_push = (pc_in == trig_pc);
      m_last_pc = pc_in;
      m_last_valid = 1'b1;
    end else if (m_phase == PH_ARMED) begin
      if (pc_in == trig_pc) begin
        try_push = 1'b1;
        nxt = PH_CAPTURE;
      end
    end else if (m_phase == PH_CAPTURE) begin
      try_push = 1'b1;
    end
    accept = try_push && (exp_q.size() < DEPTH || pop);
    if (try_push && !accept) begin
      if (m_phase == PH_CAPTURE) nxt = PH_DONE;
      else m_ovf = 1'b1;
    end
    if (exp_q.size() != 0 && rd_ready) begin
      if (m_idx == 4) begin
        void'(exp_q.pop_front());
        m_idx = 0;
      end else m_idx++;
    end
    if (accept) exp_q.push_back({alu_in, instr_in, pc_in});
    m_phase = nxt;
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic step();
    check("rd_valid", rd_valid, exp_q.size() != 0);
    check("rd_data", rd_data, m_byte());
    check("rd_last", rd_last, (exp_q.size() != 0) && (m_idx == 4));
    check("level", level, exp_q.size());
    check("overflow", overflow, m_ovf);
    check("trig_done", trig_done, m_phase == PH_DONE);
    if (rd_valid && rd_ready) got_q.push_back({rd_last, rd_data});
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    capture_en = 1'b0; rd_ready = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    logic [15:0] pcs[3];
    logic [7:0]  exp_b;
    logic [15:0] first_pc;
    rst_n = 1'b0; capture_en = 1'b0; trig_mode = 2'b00; trig_pc = 16'h0;
    pc_in = 16'h0; instr_in = 16'h0; alu_in = 8'h0; clear = 1'b0; rd_ready = 1'b0;
    model_reset();
    m_mode = 2'b00; m_last_pc = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Every-cycle capture with continuous draining.
    got_q.delete();
    pcs[0] = 16'h0010; pcs[1] = 16'h0011; pcs[2] = 16'h0012;
    trig_mode = 2'b00; instr_in = 16'hA5C3; alu_in = 8'h7E; rd_ready = 1'b1;
    capture_en = 1'b1; pc_in = 16'h000F;
    step();
    for (int i = 0; i < 3; i++) begin
      pc_in = pcs[i];
      step();
    end
    capture_en = 1'b0;
    repeat (20) step();
    check("drain_count", got_q.size(), 15);
    for (int i = 0; i < 15 && i < got_q.size(); i++) begin
      case (i % 5)
        0: exp_b = pcs[i/5][7:0];
        1: exp_b = 8'h00;
        2: exp_b = 8'hC3;
        3: exp_b = 8'hA5;
        default: exp_b = 8'h7E;
      endcase
      check("drain_byte", got_q[i], {(i % 5) == 4, exp_b});
    end
    check("drain_level", level, 0);

    // Overflow with no draining.
    do_clear();
    rd_ready = 1'b0; capture_en = 1'b1; trig_mode = 2'b00;
    first_pc = 16'h0201;
    for (int i = 0; i < 11; i++) begin
      pc_in = 16'h0200 + 16'(i);
      step();
    end
    check("ovf_level", level, DEPTH);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", rd_data, first_pc[7:0]);
    do_clear();
    check("clr_level", level, 0);
    check("clr_ovf", overflow, 1'b0);

    // PC-change capture.
    trig_mode = 2'b01; capture_en = 1'b1; pc_in = 16'h0040;
    step();
    repeat (4) step();
    pc_in = 16'h0041;
    repeat (3) step();
    capture_en = 1'b0;
    step();
    check("chg_level", level, 2);
    check("chg_head0", rd_data, 8'h40);
    rd_ready = 1'b1;
    repeat (5) step();
    rd_ready = 1'b0;
    check("chg_head1", rd_data, 8'h41);

    // One-shot capture from a PC match.
    do_clear();
    trig_mode = 2'b11; trig_pc = 16'h0100; capture_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc_in = 16'h00FC + 16'(i);
      step();
    end
    check("os_level", level, DEPTH);
    check("os_done", trig_done, 1'b1);
    check("os_ovf", overflow, 1'b0);
    check("os_head", rd_data, 8'h00);
    capture_en = 1'b0;
    step();
    check("os_done_clr", trig_done, 1'b0);

    // Full FIFO: push alongside the pop of a finished entry.
    do_clear();
    trig_mode = 2'b00; capture_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pc_in = 16'h0500 + 16'(i);
      step();
    end
    rd_ready = 1'b1;
    capture_en = 1'b0; step();
    capture_en = 1'b1; step();
    capture_en = 1'b0; step();
    capture_en = 1'b1; step();
    check("fp_idx4", rd_last, 1'b1);
    pc_in = 16'h05AA; step();
    check("fp_level", level, DEPTH);
    check("fp_ovf", overflow, 1'b0);
    rd_ready = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_push_level", level, 0);

    // Asynchronous reset in the middle of an entry.
    capture_en = 1'b1; pc_in = 16'h0300; step();
    pc_in = 16'h0301; step();
    capture_en = 1'b0; rd_ready = 1'b1;
    repeat (2) step();
    rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", rd_valid, 1'b0);
    check("rst_level", level, 0);
    check("rst_data", rd_data, 8'h00);
    model_reset();
    #2 rst_n = 1'b1;
    capture_en = 1'b1; pc_in = 16'h0355; step();
    pc_in = 16'h0356; step();
    capture_en = 1'b0;
    check("rst_new_byte0", rd_data, 8'h56);
    check("rst_new_last", rd_last, 1'b0);

    // Random traffic.
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      capture_en = ($urandom_range(0, 15) != 0);
      trig_mode  = 2'($urandom_range(0, 3));
      trig_pc    = 16'h0020 + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) pc_in = 16'h0020 + 16'($urandom_range(0, 3));
      instr_in   = 16'($urandom);
      alu_in     = 8'($urandom);
      rd_ready   = ($urandom_range(0, 1) == 1);
      clear      = ($urandom_range(0, 63) == 0);
      step();
    end
    clear = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
